// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the EX-stage ALU control and its RV32M sequencer.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ALU_OP_MEM    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_JUMP   = 2'b11
    } alu_op_e;

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_SUB    = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SLL    = 5'b00110,
        OP_SRA    = 5'b00111,
        OP_BEQ    = 5'b01000,
        OP_BNE    = 5'b01001,
        OP_BLT    = 5'b01010,
        OP_BGE    = 5'b01011,
        OP_SLT    = 5'b01100,
        OP_SLTU   = 5'b01101,
        OP_BLTU   = 5'b01110,
        OP_BGEU   = 5'b01111,
        OP_PASS_B = 5'b10000
    } alu_operation_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Pure combinational decode of ALUOp/funct3/funct7 into an ALU operation code,
// an illegal-instruction flag and the RV32M launch request.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 5,
    parameter int MDU_EN = 1
) (
    input  logic            valid,
    input  logic [1:0]      alu_op,
    input  logic            is_imm,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    output logic [OP_W-1:0] operation,
    output logic            illegal,
    output logic            is_mdu
);

    alu_operation_e code;
    logic           bad;
    logic           muldiv;

    always_comb begin
        code   = OP_ADD;
        bad    = 1'b0;
        muldiv = 1'b0;
        case (alu_op_e'(alu_op))
            ALU_OP_MEM:  code = OP_ADD;
            ALU_OP_JUMP: code = OP_PASS_B;
            ALU_OP_BRANCH: begin
                case (funct3)
                    3'b000:  code = OP_BEQ;
                    3'b001:  code = OP_BNE;
                    3'b100:  code = OP_BLT;
                    3'b101:  code = OP_BGE;
                    3'b110:  code = OP_BLTU;
                    3'b111:  code = OP_BGEU;
                    default: bad  = 1'b1;
                endcase
            end
            ALU_OP_RTYPE: begin
                if (!is_imm && funct7 == FUNCT7_MULDIV) begin
                    // M instructions keep ADD on the ALU; the result comes from the MDU.
                    muldiv = 1'b1;
                    bad    = (MDU_EN == 0);
                end else begin
                    case (funct3)
                        3'b000: code = (!is_imm && funct7 == FUNCT7_ALT) ? OP_SUB : OP_ADD;
                        3'b001: code = OP_SLL;
                        3'b010: code = OP_SLT;
                        3'b011: code = OP_SLTU;
                        3'b100: code = OP_XOR;
                        3'b101: code = funct7[5] ? OP_SRA : OP_SRL;
                        3'b110: code = OP_OR;
                        3'b111: code = OP_AND;
                    endcase
                    // Shifts check funct7 even for immediates; other I-types carry imm bits there.
                    if (funct3 == 3'b001)
                        bad = (funct7 != FUNCT7_BASE);
                    else if (funct3 == 3'b101)
                        bad = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                    else if (!is_imm)
                        bad = (funct7 != FUNCT7_BASE) && !(funct3 == 3'b000 && funct7 == FUNCT7_ALT);
                end
            end
        endcase
        if (bad)
            code = OP_ADD;
    end

    assign operation = OP_W'(code);
    assign illegal   = valid & bad;
    assign is_mdu    = (MDU_EN != 0) & valid & muldiv;

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: combinational decode plus the RV32M launch/stall
// sequencer with a watchdog that aborts a hung multiply/divide.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int MDU_EN  = 1,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [1:0]      alu_op_i,
    input  logic            is_imm_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic            flush_i,
    input  logic            mdu_done_i,
    output logic [OP_W-1:0] operation_o,
    output logic            illegal_o,
    output logic            mdu_start_o,
    output logic [2:0]      mdu_op_o,
    output logic            mdu_kill_o,
    output logic            stall_o,
    output logic            res_sel_o,
    output logic            timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             is_mdu;
    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       mop_reg, mop_next;
    logic             tout_reg, tout_next;
    logic             start, kill, stall, rsel;

    alu_op_decode #(
        .OP_W   (OP_W),
        .MDU_EN (MDU_EN)
    ) u_decode (
        .valid     (valid_i),
        .alu_op    (alu_op_i),
        .is_imm    (is_imm_i),
        .funct7    (funct7_i),
        .funct3    (funct3_i),
        .operation (operation_o),
        .illegal   (illegal_o),
        .is_mdu    (is_mdu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mop_reg   <= '0;
            tout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mop_reg   <= mop_next;
            tout_reg  <= tout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mop_next   = mop_reg;
        tout_next  = tout_reg;
        start      = 1'b0;
        kill       = 1'b0;
        stall      = 1'b0;
        rsel       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (is_mdu && !flush_i) begin
                    start      = 1'b1;
                    stall      = 1'b1;
                    mop_next   = funct3_i;
                    cnt_next   = '0;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall    = 1'b1;
                cnt_next = cnt_reg + CNT_W'(1);
                // Flush beats a same-cycle done; done beats a same-cycle timeout.
                if (flush_i) begin
                    kill       = 1'b1;
                    stall      = 1'b0;
                    state_next = ST_IDLE;
                end else if (mdu_done_i) begin
                    state_next = ST_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    tout_next  = 1'b1;
                    kill       = 1'b1;
                    stall      = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                rsel       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Launch terms are combinational from inputs, so mask them while reset is held.
    assign stall_o   = stall & rst_n;
    assign res_sel_o = rsel;
    assign timeout_o = tout_reg;

    generate
        if (MDU_EN != 0) begin : g_mdu
            assign mdu_start_o = start & rst_n;
            assign mdu_op_o    = mop_reg;
            assign mdu_kill_o  = kill;
        end else begin : g_no_mdu
            assign mdu_start_o = 1'b0;
            assign mdu_op_o    = 3'b000;
            assign mdu_kill_o  = 1'b0;
        end
    endgenerate

endmodule
